muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative multiply/divide responder that owns the HI/LO register pair. The EX stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO requests to it over a start/busy/done handshake and reads HI/LO for MFHI/MFLO. The EX stage stalls while busy=1. This block replaces single-cycle HI/LO arithmetic with a radix-2 shift-add multiplier and a restoring divider, so the datapath is small.

Parameters:
XLEN, 32, operand width; HI and LO are each XLEN bits.
DIVZ_LO, all-ones (XLEN bits), value written to LO on divide-by-zero.

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  synchronous, active-high reset
start  input  1  request strobe; sampled only while busy=0
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x ignored
rs  input  XLEN  operand A: multiplicand, dividend, or MTHI/MTLO data
rt  input  XLEN  operand B: multiplier or divisor
busy  output  1  high while a MULT or DIV operation is in flight
done  output  1  one-cycle pulse when HI/LO receive an arithmetic result
dz  output  1  high together with done when the divide was by zero; otherwise 0
HI  output  XLEN  HI register
LO  output  XLEN  LO register

Behaviour:
- Single clock CLK. RST is synchronous and active-high. While RST=1 the next edge sets state=IDLE, HI=0, LO=0, busy=0, done=0, dz=0, and clears the counter. RST has priority over every other input.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1, op=MTHI or MTLO: the same edge writes HI or LO with rs. No busy, no done.
- IDLE, start=1, op=11x: no effect.
- IDLE, start=1, op=MULT or MULTU: latch |rs| and |rt|, treating values as unsigned for MULTU. Record the result sign (rs[XLEN-1]^rt[XLEN-1]) for MULT only. Clear the 2*XLEN accumulator and count. Go to MUL; busy=1 from the next cycle.
- MUL: one iteration per cycle. If the multiplier LSB is 1, add the multiplicand to the upper half. Then shift the accumulator right 1. After XLEN iterations go to FIX.
- IDLE, start=1, op=DIV or DIVU, rt!=0: latch magnitudes. Record the quotient sign (rs^rt MSB) and the remainder sign (rs MSB). Go to DIV.
- DIV: one restoring step per cycle: shift {rem, quo} left 1, trial-subtract the divisor, keep the result if it is non-negative, and set the quotient bit. After XLEN steps go to FIX.
- FIX: apply two's-complement negation per the recorded signs. Write {HI,LO} = product, or LO = quotient and HI = remainder. Set done=1 for exactly one cycle, set busy=0, and return to IDLE.
- Latency: start sampled at edge E0; HI/LO valid and done=1 after edge E(XLEN+1), i.e. 33 cycles for XLEN=32.
- Divide by zero (rt==0, DIV or DIVU): no iteration. The edge E0 writes LO=DIVZ_LO and HI=rs, and sets done=1 and dz=1 for one cycle. busy never rises.
- Signed division truncates toward zero; the remainder takes the dividend's sign. For 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no exception.
- start while busy=1 is ignored entirely, including MTHI/MTLO. The EX stage must hold the request until busy=0.
- HI/LO hold their old values throughout MUL and DIV. They change only at FIX, at a divide-by-zero, or on an MT* write.
- RST mid-operation aborts the operation: the result is lost, HI=LO=0, and done does not pulse.

Optional Feature:
MULDIV_EARLY_OUT_EN:
- Defined: MUL exits to FIX after any iteration that leaves the remaining multiplier bits all zero, with a minimum of 1 iteration. On exit the accumulator is realigned by the remaining shift count, so the result equals the full-iteration result. Latency becomes (iterations + 1) cycles after E0. DIV is unchanged.
- Undefined: fixed XLEN iterations as above.

Test Plan:
1. MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001; done high exactly 1 cycle; busy high for cycles 1..33.
2. MULT rs=0xFFFFFFFD (-3) rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21); dz=0.
3. DIV rs=0xFFFFFFF9 (-7) rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
4. DIVU rs=0x1234 rt=0 -> next cycle done=1, dz=1, LO=0xFFFFFFFF, HI=0x1234; busy stays 0.
5. Start DIVU 100/7. At cycle 5 issue MTHI rs=0xAA -> ignored; final LO=14, HI=2. Repeat the DIVU and assert RST at cycle 10 -> HI=LO=0, busy=0, no done pulse.
6. With MULDIV_EARLY_OUT_EN: MULTU rs=5 rt=3 -> LO=15, HI=0, done after 3 cycles. Without the macro: same result after 33 cycles.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage (master) and muldiv_unit (slave).
interface muldiv_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            start;
   logic [2:0]      op;
   logic [XLEN-1:0] rs;
   logic [XLEN-1:0] rt;
   logic            busy;
   logic            done;
   logic            dz;
   logic [XLEN-1:0] HI;
   logic [XLEN-1:0] LO;

   modport master (output start, op, rs, rt, input busy, done, dz, HI, LO);
   modport slave  (input start, op, rs, rt, output busy, done, dz, HI, LO);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiplier, restoring divider.
// Optional macro MULDIV_EARLY_OUT_EN: MUL exits once the remaining multiplier bits are zero.
module muldiv_unit #(
   parameter int unsigned     XLEN    = 32,
   parameter logic [XLEN-1:0] DIVZ_LO = '1
) (
   input logic          CLK,
   input logic          RST,
   muldiv_unit_if.slave bus
);
   localparam int unsigned CntW = $clog2(XLEN);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [2*XLEN-1:0] acc_q, acc_d;     // product, or {remainder, quotient}
   logic [XLEN-1:0]   opa_q, opa_d;     // multiplicand or divisor magnitude
   logic [XLEN-1:0]   mplr_q, mplr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              is_mul_q, is_mul_d;
   logic              neg_hi_q, neg_hi_d, neg_lo_q, neg_lo_d;
   logic              done_q, done_d, dz_q, dz_d;

   logic              is_signed;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              last_iter;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_acc;
   logic [XLEN-1:0]   mplr_nxt;
   logic [XLEN:0]     rem_sh, rem_diff;
   logic              div_ge;
   logic [2*XLEN-1:0] div_acc;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix;

   assign is_signed = ~bus.op[0];
   assign mag_a     = (is_signed && bus.rs[XLEN-1]) ? -bus.rs : bus.rs;
   assign mag_b     = (is_signed && bus.rt[XLEN-1]) ? -bus.rt : bus.rt;
   assign last_iter = (cnt_q == CntW'(XLEN - 1));

   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{mplr_q[0]}} & opa_q};
   assign mul_acc  = {mul_sum, acc_q[XLEN-1:1]};
   assign mplr_nxt = mplr_q >> 1;

   // Shift the next dividend bit into the partial remainder, then trial-subtract.
   assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign div_ge   = (rem_sh >= {1'b0, opa_q});
   assign rem_diff = rem_sh - {1'b0, opa_q};
   assign div_acc  = div_ge ? {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                            : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

   assign prod_fix = neg_lo_q ? -acc_q : acc_q;
   assign quo_fix  = neg_lo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   assign rem_fix  = neg_hi_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

   always_comb begin
      state_d  = state_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      acc_d    = acc_q;
      opa_d    = opa_q;
      mplr_d   = mplr_q;
      cnt_d    = cnt_q;
      is_mul_d = is_mul_q;
      neg_hi_d = neg_hi_q;
      neg_lo_d = neg_lo_q;
      done_d   = 1'b0;
      dz_d     = 1'b0;

      case (state_q)
         StIdle: begin
            if (bus.start) begin
               case (bus.op)
                  3'b000, 3'b001: begin
                     opa_d    = mag_a;
                     mplr_d   = mag_b;
                     acc_d    = '0;
                     cnt_d    = '0;
                     is_mul_d = 1'b1;
                     neg_lo_d = is_signed & (bus.rs[XLEN-1] ^ bus.rt[XLEN-1]);
                     neg_hi_d = neg_lo_d;
                     state_d  = StMul;
                  end
                  3'b010, 3'b011: begin
                     if (bus.rt == '0) begin
                        lo_d   = DIVZ_LO;
                        hi_d   = bus.rs;
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                     end else begin
                        acc_d    = {{XLEN{1'b0}}, mag_a};
                        opa_d    = mag_b;
                        cnt_d    = '0;
                        is_mul_d = 1'b0;
                        neg_lo_d = is_signed & (bus.rs[XLEN-1] ^ bus.rt[XLEN-1]);
                        neg_hi_d = is_signed & bus.rs[XLEN-1];
                        state_d  = StDiv;
                     end
                  end
                  3'b100:  hi_d = bus.rs;
                  3'b101:  lo_d = bus.rs;
                  default: ;
               endcase
            end
         end
         StMul: begin
            acc_d  = mul_acc;
            mplr_d = mplr_nxt;
            cnt_d  = cnt_q + CntW'(1);
            if (last_iter) state_d = StFix;
`ifdef MULDIV_EARLY_OUT_EN
            // Remaining iterations would only shift; apply them all at once.
            if (mplr_nxt == '0) begin
               acc_d   = mul_acc >> (CntW'(XLEN - 1) - cnt_q);
               state_d = StFix;
            end
`endif
         end
         StDiv: begin
            acc_d = div_acc;
            cnt_d = cnt_q + CntW'(1);
            if (last_iter) state_d = StFix;
         end
         StFix: begin
            if (is_mul_q) begin
               {hi_d, lo_d} = prod_fix;
            end else begin
               lo_d = quo_fix;
               hi_d = rem_fix;
            end
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= StIdle;
         hi_q     <= '0;
         lo_q     <= '0;
         acc_q    <= '0;
         opa_q    <= '0;
         mplr_q   <= '0;
         cnt_q    <= '0;
         is_mul_q <= 1'b0;
         neg_hi_q <= 1'b0;
         neg_lo_q <= 1'b0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         acc_q    <= acc_d;
         opa_q    <= opa_d;
         mplr_q   <= mplr_d;
         cnt_q    <= cnt_d;
         is_mul_q <= is_mul_d;
         neg_hi_q <= neg_hi_d;
         neg_lo_q <= neg_lo_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
      end
   end

   assign bus.busy = (state_q != StIdle);
   assign bus.done = done_q;
   assign bus.dz   = dz_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO/dz queued at issue, checked at done.
`timescale 1ns/1ps
module tb_muldiv_unit;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   muldiv_unit_if #(.XLEN(32)) bus ();
   muldiv_unit #(.XLEN(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   exp_t sb[$];
   int   vec = 0;
   int   err = 0;

   function automatic exp_t model(input logic [2:0] o, input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t        e;
      longint      p;
      logic [63:0] u;
      e.hi = '0;
      e.lo = '0;
      e.dz = 1'b0;
      case (o)
         3'b000: begin
            p = longint'($signed(a)) * longint'($signed(b));
            {e.hi, e.lo} = p;
         end
         3'b001: begin
            u = {32'd0, a} * {32'd0, b};
            {e.hi, e.lo} = u;
         end
         3'b010, 3'b011: begin
            if (b == 32'd0) begin
               e.hi = a;
               e.lo = 32'hFFFF_FFFF;
               e.dz = 1'b1;
            end else if (o == 3'b010) begin
               p    = longint'($signed(a)) / longint'($signed(b));
               e.lo = p[31:0];
               p    = longint'($signed(a)) % longint'($signed(b));
               e.hi = p[31:0];
            end else begin
               e.lo = a / b;
               e.hi = a % b;
            end
         end
         default: ;
      endcase
      return e;
   endfunction

   function automatic int exp_latency(input logic [2:0] o, input logic [31:0] b);
      logic [31:0] m;
      int          bits;
      if (o[1] && b == 32'd0) return 0;
      m    = (o == 3'b000 && b[31]) ? (32'd0 - b) : b;
      bits = 0;
      while (m != 32'd0) begin
         bits++;
         m = m >> 1;
      end
      if (bits == 0) bits = 1;
`ifdef MULDIV_EARLY_OUT_EN
      if (!o[1]) return bits + 1;
`endif
      return 33;
   endfunction

   // Issue one arithmetic op at a negedge; inj >= 0 fires an MTHI at that in-flight cycle.
   task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int inj);
      exp_t        e;
      int          lat, exp_l, busy_bad, hold_bad;
      logic [31:0] hi0, lo0;
      exp_l = exp_latency(o, b);
      sb.push_back(model(o, a, b));
      hi0 = bus.HI;
      lo0 = bus.LO;
      bus.start = 1'b1;
      bus.op    = o;
      bus.rs    = a;
      bus.rt    = b;
      @(posedge CLK);
      #1 bus.start = 1'b0;
      lat      = 0;
      busy_bad = 0;
      hold_bad = 0;
      @(negedge CLK);
      while (bus.done !== 1'b1 && lat < 200) begin
         if (bus.busy !== 1'b1) busy_bad++;
         if (bus.HI !== hi0 || bus.LO !== lo0) hold_bad++;
         if (lat == inj) begin
            bus.start = 1'b1;
            bus.op    = 3'b100;
            bus.rs    = 32'h0000_00AA;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge CLK);
         lat++;
      end
      bus.start = 1'b0;
      e = sb.pop_front();
      vec++;
      if (lat != exp_l) begin
         err++;
         $display("FAIL %s latency: got %0d cycles, want %0d", nm, lat, exp_l);
      end
      vec++;
      if (busy_bad != 0) begin
         err++;
         $display("FAIL %s busy_inflight: %0d cycles with busy!=1, want 0", nm, busy_bad);
      end
      vec++;
      if (hold_bad != 0) begin
         err++;
         $display("FAIL %s hilo_hold: %0d cycles HI/LO changed in flight, want 0", nm, hold_bad);
      end
      vec++;
      if (bus.HI !== e.hi || bus.LO !== e.lo) begin
         err++;
         $display("FAIL %s result: HI=%h LO=%h, want HI=%h LO=%h", nm, bus.HI, bus.LO,
                  e.hi, e.lo);
      end
      vec++;
      if (bus.dz !== e.dz) begin
         err++;
         $display("FAIL %s dz: got %b, want %b", nm, bus.dz, e.dz);
      end
      vec++;
      if (bus.busy !== 1'b0) begin
         err++;
         $display("FAIL %s busy_at_done: got %b, want 0", nm, bus.busy);
      end
      @(negedge CLK);
      vec++;
      if (bus.done !== 1'b0 || bus.dz !== 1'b0) begin
         err++;
         $display("FAIL %s pulse_width: done=%b dz=%b one cycle later, want 0 0", nm,
                  bus.done, bus.dz);
      end
   endtask

   task automatic mt(input logic [2:0] o, input logic [31:0] a);
      bus.start = 1'b1;
      bus.op    = o;
      bus.rs    = a;
      @(posedge CLK);
      #1 bus.start = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      bus.op    = 3'b000;
      bus.rs    = '0;
      bus.rt    = '0;
      RST       = 1'b1;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      vec++;
      if ({bus.HI, bus.LO} !== 64'd0) begin
         err++;
         $display("FAIL reset_hilo: HI=%h LO=%h, want 0 0", bus.HI, bus.LO);
      end
      vec++;
      if ({bus.busy, bus.done, bus.dz} !== 3'b000) begin
         err++;
         $display("FAIL reset_flags: busy/done/dz=%b, want 000", {bus.busy, bus.done, bus.dz});
      end
   endtask

   task automatic test_mt();
      mt(3'b100, 32'h1234_5678);
      vec++;
      if (bus.HI !== 32'h1234_5678 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         err++;
         $display("FAIL mthi: HI=%h done=%b busy=%b, want 12345678 0 0", bus.HI, bus.done,
                  bus.busy);
      end
      mt(3'b101, 32'h9ABC_DEF0);
      vec++;
      if (bus.LO !== 32'h9ABC_DEF0 || bus.HI !== 32'h1234_5678) begin
         err++;
         $display("FAIL mtlo: HI=%h LO=%h, want 12345678 9abcdef0", bus.HI, bus.LO);
      end
      mt(3'b110, 32'h0);
      mt(3'b111, 32'h0);
      vec++;
      if (bus.HI !== 32'h1234_5678 || bus.LO !== 32'h9ABC_DEF0 || bus.busy !== 1'b0) begin
         err++;
         $display("FAIL op_11x: HI=%h LO=%h busy=%b, want 12345678 9abcdef0 0", bus.HI,
                  bus.LO, bus.busy);
      end
   endtask

   task automatic test_mul();
      run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
      run_op("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'd7, -1);
      run_op("mult_negneg", 3'b000, 32'h8000_0000, 32'h8000_0000, -1);
   endtask

   task automatic test_div();
      run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, -1);
      run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, -1);
      run_op("divu_big", 3'b011, 32'hFFFF_FFFF, 32'd10, -1);
   endtask

   task automatic test_divz();
      run_op("divu_z", 3'b011, 32'h0000_1234, 32'd0, -1);
      run_op("div_z", 3'b010, 32'h8765_4321, 32'd0, -1);
   endtask

   task automatic test_busy_ignore();
      run_op("divu_mthi_ign", 3'b011, 32'd100, 32'd7, 4);
   endtask

   task automatic test_reset_abort();
      int done_cnt;
      done_cnt  = 0;
      bus.start = 1'b1;
      bus.op    = 3'b011;
      bus.rs    = 32'd100;
      bus.rt    = 32'd7;
      @(posedge CLK);
      #1 bus.start = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge CLK);
         if (bus.done === 1'b1) done_cnt++;
         if (c == 9) RST = 1'b1;
         if (c == 10) begin
            RST = 1'b0;
            vec++;
            if ({bus.HI, bus.LO} !== 64'd0 || bus.busy !== 1'b0) begin
               err++;
               $display("FAIL abort_state: HI=%h LO=%h busy=%b, want 0 0 0", bus.HI, bus.LO,
                        bus.busy);
            end
         end
      end
      vec++;
      if (done_cnt != 0) begin
         err++;
         $display("FAIL abort_done: %0d done pulses, want 0", done_cnt);
      end
   endtask

   task automatic test_early_out();
      run_op("multu_5x3", 3'b001, 32'd5, 32'd3, -1);
      run_op("mult_x0", 3'b000, 32'hDEAD_BEEF, 32'd0, -1);
      run_op("mult_negm", 3'b000, 32'd9, 32'hFFFF_FFFC, -1);
   endtask

   task automatic test_back_to_back();
      logic [2:0]  o;
      logic [31:0] a, b;
      for (int i = 0; i < 10; i++) begin
         o = 3'($urandom_range(0, 3));
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
         run_op("rand", o, a, b, -1);
      end
   endtask

   initial begin
      test_reset();
      test_mt();
      test_mul();
      test_div();
      test_divz();
      test_busy_ignore();
      test_reset_abort();
      test_early_out();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
